soc_system_zoom_cmd_ctrl: RTL and testbench

//   Avalon-MM slave sequencing zoom-mode commands from the HPS to the zoom datapath.

---
 rtl/soc_system_zoom_cmd_ctrl.sv | 138 +++++++++++++
 tb/tb_soc_system_zoom_cmd_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_zoom_cmd_ctrl.sv
// Avalon-MM command sequencer for the zoom datapath: one running op plus one queued slot.
// Optional macro ZOOM_CMD_CYCLE_COUNT_EN adds the CNT register (RUN cycles of the last op).
module soc_system_zoom_cmd_ctrl #(
  parameter int          OPT_W       = 3,
  parameter logic [23:0] TIMEOUT_CYC = 24'hFFFFFF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             cmd_valid,
  output logic [OPT_W-1:0] cmd_opt,
  input  logic             cmd_ready,
  input  logic             op_done,
  output logic             op_abort,
  output logic             irq
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RUN = 2'd2} state_t;

  state_t           state_reg;
  logic [OPT_W-1:0] pend_opt_reg;
  logic             pending_reg;
  logic             done_reg;
  logic             err_reg;
  logic             overrun_reg;
  logic [1:0]       mask_reg;
  logic [23:0]      counter_reg;
`ifdef ZOOM_CMD_CYCLE_COUNT_EN
  logic [23:0]      cnt_reg;
`endif

  logic        wr;
  logic        busy;
  logic [31:0] rd_mux;
  logic        unused_wd;

  assign wr        = chipselect & ~write_n;
  assign busy      = (state_reg != IDLE);
  assign irq       = |({err_reg, done_reg} & mask_reg);
  assign unused_wd = &{1'b0, writedata};

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0: rd_mux[OPT_W-1:0] = cmd_opt;
      2'd1: rd_mux[4:0]       = {overrun_reg, pending_reg, err_reg, done_reg, busy};
      2'd2: rd_mux[1:0]       = mask_reg;
      2'd3: begin
`ifdef ZOOM_CMD_CYCLE_COUNT_EN
        rd_mux[23:0] = cnt_reg;
`else
        rd_mux = '0;
`endif
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      readdata     <= '0;
      cmd_valid    <= 1'b0;
      cmd_opt      <= '0;
      op_abort     <= 1'b0;
      pend_opt_reg <= '0;
      pending_reg  <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      overrun_reg  <= 1'b0;
      mask_reg     <= '0;
      counter_reg  <= '0;
`ifdef ZOOM_CMD_CYCLE_COUNT_EN
      cnt_reg      <= '0;
`endif
    end else begin
      readdata <= rd_mux;
      op_abort <= 1'b0;

      // Clears come first so a same-cycle hardware set below overrides them.
      if (wr && address == 2'd1) begin
        if (writedata[1]) done_reg    <= 1'b0;
        if (writedata[2]) err_reg     <= 1'b0;
        if (writedata[4]) overrun_reg <= 1'b0;
      end
      if (wr && address == 2'd2)
        mask_reg <= writedata[1:0];
      if (wr && address == 2'd0) begin
        if (pending_reg) begin
          overrun_reg <= 1'b1;
        end else begin
          pending_reg  <= 1'b1;
          pend_opt_reg <= writedata[OPT_W-1:0];
        end
      end

      case (state_reg)
        IDLE: begin
          if (pending_reg) begin
            cmd_opt     <= pend_opt_reg;
            pending_reg <= 1'b0;
            cmd_valid   <= 1'b1;
            state_reg   <= REQ;
          end
        end
        REQ: begin
          if (cmd_ready) begin
            cmd_valid   <= 1'b0;
            counter_reg <= '0;
            state_reg   <= RUN;
          end
        end
        RUN: begin
          // counter_reg holds completed RUN cycles, so this cycle is number counter_reg+1.
          if (op_done) begin
            done_reg  <= 1'b1;
`ifdef ZOOM_CMD_CYCLE_COUNT_EN
            cnt_reg   <= (counter_reg == 24'hFFFFFF) ? counter_reg : counter_reg + 24'd1;
`endif
            state_reg <= IDLE;
          end else if (TIMEOUT_CYC != 24'd0 && counter_reg == TIMEOUT_CYC - 24'd1) begin
            err_reg   <= 1'b1;
            op_abort  <= 1'b1;
            state_reg <= IDLE;
          end else if (counter_reg != 24'hFFFFFF) begin
            counter_reg <= counter_reg + 24'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_system_zoom_cmd_ctrl.sv
// Directed bench for soc_system_zoom_cmd_ctrl with a queue-based command model checked every cycle.
module tb_soc_system_zoom_cmd_ctrl;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        cmd_valid;
  logic [2:0]  cmd_opt;
  logic        cmd_ready = 1'b1;
  logic        op_done = 1'b0;
  logic        op_abort;
  logic        irq;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  soc_system_zoom_cmd_ctrl #(.OPT_W(3), .TIMEOUT_CYC(24'd16)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .cmd_valid(cmd_valid), .cmd_opt(cmd_opt), .cmd_ready(cmd_ready),
    .op_done(op_done), .op_abort(op_abort), .irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_slot[$];
  bit          m_busy, m_offered, m_abort;
  bit          m_done, m_err, m_ovr;
  int          m_run, m_cnt;
  logic [2:0]  m_opt;
  logic [1:0]  m_mask;
  logic [31:0] m_rd;

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] v;
    v = 0;
    case (a)
      2'd0: v = 32'(m_opt);
      2'd1: v = {27'd0, m_ovr, m_slot.size() != 0, m_err, m_done, m_busy};
      2'd2: v = 32'(m_mask);
`ifdef ZOOM_CMD_CYCLE_COUNT_EN
      2'd3: v = 32'(m_cnt);
`endif
      default: v = 0;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m_slot.delete();
    m_busy = 0; m_offered = 0; m_abort = 0;
    m_done = 0; m_err = 0; m_ovr = 0;
    m_run = 0; m_cnt = 0; m_opt = 0; m_mask = 0; m_rd = 0;
  endtask

  task automatic model_step();
    bit had;
    int old_opt;
    bit wr;
    wr      = chipselect && !write_n;
    m_rd    = model_read(address);
    m_abort = 0;
    had     = (m_slot.size() != 0);
    old_opt = had ? m_slot[0] : 0;
    if (wr && address == 2'd1) begin
      if (writedata[1]) m_done = 0;
      if (writedata[2]) m_err  = 0;
      if (writedata[4]) m_ovr  = 0;
    end
    if (wr && address == 2'd2) m_mask = writedata[1:0];
    if (wr && address == 2'd0) begin
      if (had) m_ovr = 1;
      else m_slot.push_back(int'(writedata[2:0]));
    end
    if (!m_busy) begin
      if (had) begin
        void'(m_slot.pop_front());
        m_opt = old_opt[2:0];
        m_busy = 1; m_offered = 1;
      end
    end else if (m_offered) begin
      if (cmd_ready) begin m_offered = 0; m_run = 0; end
    end else begin
      m_run++;
      if (op_done) begin
        m_done = 1; m_cnt = m_run; m_busy = 0;
      end else if (m_run == TO) begin
        m_err = 1; m_abort = 1; m_busy = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      model_reset();
      check("rst_readdata", readdata, 0);
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_cmd_opt", cmd_opt, 0);
      check("rst_op_abort", op_abort, 0);
      check("rst_irq", irq, 0);
    end else begin
      check("readdata", readdata, m_rd);
      check("cmd_valid", cmd_valid, m_offered);
      check("cmd_opt", cmd_opt, m_opt);
      check("op_abort", op_abort, m_abort);
      check("irq", irq, |({m_err, m_done} & m_mask));
      model_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1;
    tick();
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!cmd_valid && n < 40) begin tick(); n++; end
    check("wait_cmd_valid", cmd_valid, 1);
  endtask

  task automatic accept();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
  endtask

  // After accept() the bench sits in RUN cycle 1; op_done lands in RUN cycle n.
  task automatic run_done(input int n);
    repeat (n - 1) tick();
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
  endtask

  logic [31:0] v;
  logic [31:0] cnt_exp;

  initial begin
    int n;
    // Reset held with cmd_ready high
    repeat (3) tick();
    check("reset_outputs", {readdata, 28'd0, cmd_valid, op_abort, irq, |cmd_opt}, 0);
    reset_n = 1'b1;
    cmd_ready = 1'b0;
    tick();
    rd(2'd1, v); check("stat_after_reset", v, 32'h0);

    // CMD=5, ready next cycle, op_done in RUN cycle 10
    wr(2'd0, 32'd5);
    wait_valid();
    check("first_opt", cmd_opt, 5);
    accept();
    rd(2'd1, v); check("stat_busy", v, 32'h1);
    run_done(9);
    rd(2'd1, v); check("stat_done", v, 32'h2);
`ifdef ZOOM_CMD_CYCLE_COUNT_EN
    cnt_exp = 32'd10;
`else
    cnt_exp = 32'd0;
`endif
    rd(2'd3, v); check("cnt_10", v, cnt_exp);
    wr(2'd3, 32'hFFFF);
    rd(2'd3, v); check("cnt_write_ignored", v, cnt_exp);
    check("irq_masked", irq, 0);
    wr(2'd2, 32'h1);
    check("irq_done", irq, 1);

    // Queue 2 while busy, 3 overruns and is dropped
    wr(2'd2, 32'h0);
    wr(2'd1, 32'h16);
    wr(2'd0, 32'd7);
    wait_valid();
    accept();
    wr(2'd0, 32'd2);
    wr(2'd0, 32'd3);
    rd(2'd1, v); check("stat_pend_ovr", v, 32'h19);
    op_done = 1'b1; tick(); op_done = 1'b0;
    wait_valid();
    check("queued_opt", cmd_opt, 2);
    accept();
    run_done(3);
    rd(2'd1, v); check("stat_after_queue", v, 32'h12);
    tick(); tick();
    check("no_third_cmd", cmd_valid, 0);

    // Timeout at RUN cycle 16
    wr(2'd1, 32'h16);
    wr(2'd2, 32'h2);
    wr(2'd0, 32'd4);
    wait_valid();
    accept();
    n = 0;
    while (!op_abort && n < 40) begin tick(); n++; end
    check("abort_latency", n, TO);
    tick();
    check("abort_pulse_1cyc", op_abort, 0);
    rd(2'd1, v); check("stat_err", v, 32'h4);
    check("irq_err", irq, 1);

    // op_done on the timeout cycle: done wins
    wr(2'd1, 32'h16);
    wr(2'd0, 32'd1);
    wait_valid();
    accept();
    run_done(TO);
    check("no_abort_on_done", op_abort, 0);
    rd(2'd1, v); check("stat_done_wins", v, 32'h2);
`ifdef ZOOM_CMD_CYCLE_COUNT_EN
    cnt_exp = 32'd16;
`endif
    rd(2'd3, v); check("cnt_16", v, cnt_exp);
    wr(2'd1, 32'h16);
    rd(2'd1, v); check("stat_w1c", v, 32'h0);
    check("irq_cleared", irq, 0);

    // Stall in REQ for 50 cycles
    wr(2'd0, 32'd6);
    wait_valid();
    repeat (50) tick();
    check("stall_valid", cmd_valid, 1);
    check("stall_opt", cmd_opt, 6);
    accept();
    run_done(5);
`ifdef ZOOM_CMD_CYCLE_COUNT_EN
    cnt_exp = 32'd5;
`endif
    rd(2'd3, v); check("cnt_after_stall", v, cnt_exp);

    // W1C of done in the same cycle op_done sets it
    wr(2'd1, 32'h16);
    wr(2'd0, 32'd3);
    wait_valid();
    accept();
    tick();
    address = 2'd1; writedata = 32'h2; chipselect = 1'b1; write_n = 1'b0; op_done = 1'b1;
    tick();
    chipselect = 1'b0; write_n = 1'b1; op_done = 1'b0;
    rd(2'd1, v); check("set_beats_w1c", v, 32'h2);

    // Reset mid-op with a pending command
    wr(2'd0, 32'd2);
    wait_valid();
    accept();
    wr(2'd0, 32'd3);
    reset_n = 1'b0;
    #1;
    check("async_reset_valid", cmd_valid, 0);
    tick();
    reset_n = 1'b1;
    tick();
    rd(2'd1, v); check("stat_after_midreset", v, 32'h0);
    repeat (3) tick();
    check("pending_discarded", cmd_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end
endmodule
